// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus source arbiter: FSM state encoding,
// source index type, settle counter sizing and the one-hot grant helper.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef logic [1:0] src_idx_t;

  localparam int CNT_W      = 4;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

  function automatic logic [3:0] onehot4(input src_idx_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bus_source_arbiter_if.sv
// Requester handshake plus select/data lines to the 4:1 computer_data_bus.
// The arbiter uses the slave modport; requesters and the bus use master.
interface bus_source_arbiter_if;

  logic [3:0] req;
  logic       d;
  logic       s0;
  logic       s1;
  logic       q;
  logic [3:0] ack;
  logic       busy;

  modport master (
    output req,
    output d,
    input  s0,
    input  s1,
    input  q,
    input  ack,
    input  busy
  );

  modport slave (
    input  req,
    input  d,
    output s0,
    output s1,
    output q,
    output ack,
    output busy
  );

endinterface

// File: rtl/bus_arb_pick.sv
// Combinational grant picker. BUS_ARB_RR_EN selects round-robin search from
// ptr (wrapping 3->0); otherwise fixed priority with req[0] highest.
module bus_arb_pick
  import bus_arb_pkg::*;
(
  input  logic [3:0] req,
  input  src_idx_t   ptr,
  output src_idx_t   g,
  output logic       any
);

`ifdef BUS_ARB_RR_EN
  src_idx_t idx_s;
  logic     found_s;

  // Scan the four sources starting at the pointer; first asserted one wins
  always_comb begin
    g       = ptr;
    idx_s   = ptr;
    found_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx_s = ptr + src_idx_t'(i);
      if (!found_s && req[idx_s]) begin
        g       = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
`else
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr;

  // Fixed priority, lowest index wins
  always_comb begin
    if (req[0]) begin
      g = 2'd0;
    end else if (req[1]) begin
      g = 2'd1;
    end else if (req[2]) begin
      g = 2'd2;
    end else if (req[3]) begin
      g = 2'd3;
    end else begin
      g = 2'd0;
    end
  end
`endif

  assign any = |req;

endmodule

// File: rtl/bus_source_arbiter.sv
// Clocked owner of the computer_data_bus select lines: grants one requester,
// holds s1/s0 for SETTLE_CYCLES, samples d and returns it via req/ack.
// Optional round-robin arbitration is enabled by defining BUS_ARB_RR_EN.
module bus_source_arbiter
  import bus_arb_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  bus_source_arbiter_if.slave bus
);

  if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
    $error("bus_source_arbiter: SETTLE_CYCLES=%0d outside legal range 1..15", SETTLE_CYCLES);
  end

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_r;
  src_idx_t         grant_r;
  src_idx_t         sel_r;
  logic [CNT_W-1:0] cnt_r;
  logic             q_r;
  logic [3:0]       ack_r;
  logic             busy_r;

  src_idx_t         pick_g_s;
  logic             pick_any_s;
  src_idx_t         ptr_s;
  logic             req_g_s;
  logic             complete_s;

  assign req_g_s    = bus.req[grant_r];
  assign complete_s = (state_r == ST_SETTLE) && req_g_s && (cnt_r == {CNT_W{1'b0}});

  bus_arb_pick u_pick (
    .req (bus.req),
    .ptr (ptr_s),
    .g   (pick_g_s),
    .any (pick_any_s)
  );

`ifdef BUS_ARB_RR_EN
  src_idx_t ptr_r;

  // Round-robin pointer moves past the winner only when a transfer completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 2'd0;
    end else if (complete_s) begin
      ptr_r <= grant_r + 2'd1;
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = 2'd0;
`endif

  // Transaction FSM; select lines are only ever loaded when leaving IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      grant_r <= 2'd0;
      sel_r   <= 2'd0;
      cnt_r   <= {CNT_W{1'b0}};
      q_r     <= 1'b0;
      ack_r   <= 4'b0000;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            grant_r <= pick_g_s;
            sel_r   <= pick_g_s;
            cnt_r   <= SETTLE_LOAD;
            busy_r  <= 1'b1;
            state_r <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!req_g_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (cnt_r == {CNT_W{1'b0}}) begin
            q_r     <= bus.d;
            ack_r   <= onehot4(grant_r);
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if (!req_g_s) begin
            ack_r   <= 4'b0000;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          ack_r   <= 4'b0000;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.s1   = sel_r[1];
  assign bus.s0   = sel_r[0];
  assign bus.q    = q_r;
  assign bus.ack  = ack_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed bench for bus_source_arbiter with a model of computer_data_bus
// (i0..i3 = 1,0,1,0). Expectations follow BUS_ARB_RR_EN when it is defined.
module tb_bus_source_arbiter;
  import bus_arb_pkg::*;

`ifdef BUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] ack;
    logic       q;
    logic       busy;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [3:0] src_vals;
  int n_cmp;
  int n_err;
  vec_t vecs [24];
  int exp_g [5];

  bus_source_arbiter_if bus_i ();

  bus_source_arbiter #(.SETTLE_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  assign bus_i.d = src_vals[{bus_i.s1, bus_i.s0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input int k);
    logic [3:0] r;
    r = 4'b0000;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] r, input logic [1:0] s,
                              input logic [3:0] a, input logic qq, input logic b);
    vec_t v;
    v.req = r; v.sel = s; v.ack = a; v.q = qq; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] s, input logic [3:0] a,
                         input logic qq, input logic b);
    chk({tag, ".sel"},  32'({bus_i.s1, bus_i.s0}), 32'(s));
    chk({tag, ".ack"},  32'(bus_i.ack), 32'(a));
    chk({tag, ".q"},    32'(bus_i.q), 32'(qq));
    chk({tag, ".busy"}, 32'(bus_i.busy), 32'(b));
  endtask

  initial begin
    logic [1:0] s12;
    logic [1:0] s20;
    n_cmp = 0;
    n_err = 0;
    src_vals = 4'b0101;
    rst_n = 1'b0;
    bus_i.req = 4'b0000;

    s12 = RR ? 2'b11 : 2'b00;
    s20 = RR ? 2'b11 : 2'b01;
    // single request with a late competitor, then a second grant
    vecs[0]  = mk(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0);
    vecs[1]  = mk(4'b0100, 2'b10, 4'b0000, 1'b0, 1'b1);
    vecs[2]  = mk(4'b0101, 2'b10, 4'b0000, 1'b0, 1'b1);
    vecs[3]  = mk(4'b0101, 2'b10, 4'b0100, 1'b1, 1'b1);
    vecs[4]  = mk(4'b0001, 2'b10, 4'b0000, 1'b1, 1'b0);
    vecs[5]  = mk(4'b0001, 2'b00, 4'b0000, 1'b1, 1'b1);
    vecs[6]  = mk(4'b0001, 2'b00, 4'b0000, 1'b1, 1'b1);
    vecs[7]  = mk(4'b0001, 2'b00, 4'b0001, 1'b1, 1'b1);
    vecs[8]  = mk(4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0);
    // abort of source 3 one edge after grant
    vecs[9]  = mk(4'b1000, 2'b11, 4'b0000, 1'b1, 1'b1);
    vecs[10] = mk(4'b0000, 2'b11, 4'b0000, 1'b1, 1'b0);
    vecs[11] = mk(4'b0000, 2'b11, 4'b0000, 1'b1, 1'b0);
    // pointer untouched by the abort: RR from 1 picks 3, fixed picks 0
    vecs[12] = mk(4'b1001, s12, 4'b0000, 1'b1, 1'b1);
    vecs[13] = mk(4'b1001, s12, 4'b0000, 1'b1, 1'b1);
    vecs[14] = mk(4'b1001, s12, RR ? 4'b1000 : 4'b0001, RR ? 1'b0 : 1'b1, 1'b1);
    vecs[15] = mk(4'b0000, s12, 4'b0000, RR ? 1'b0 : 1'b1, 1'b0);
    // req 1010: source 1 first, then re-grant after release
    vecs[16] = mk(4'b1010, 2'b01, 4'b0000, RR ? 1'b0 : 1'b1, 1'b1);
    vecs[17] = mk(4'b1010, 2'b01, 4'b0000, RR ? 1'b0 : 1'b1, 1'b1);
    vecs[18] = mk(4'b1010, 2'b01, 4'b0010, 1'b0, 1'b1);
    vecs[19] = mk(4'b1000, 2'b01, 4'b0000, 1'b0, 1'b0);
    vecs[20] = mk(4'b1010, s20, 4'b0000, 1'b0, 1'b1);
    vecs[21] = mk(4'b1010, s20, 4'b0000, 1'b0, 1'b1);
    vecs[22] = mk(4'b1010, s20, RR ? 4'b1000 : 4'b0010, 1'b0, 1'b1);
    vecs[23] = mk(4'b0000, s20, 4'b0000, 1'b0, 1'b0);

    #2;
    chk_all("reset", 2'b00, 4'b0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      bus_i.req = vecs[i].req;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].ack, vecs[i].q, vecs[i].busy);
    end

    // asynchronous reset in the middle of SETTLE, with q=1 beforehand
    bus_i.req = 4'b0001;
    repeat (3) step();
    chk("pre_rst.q", 32'(bus_i.q), 32'd1);
    bus_i.req = 4'b0000;
    step();
    bus_i.req = 4'b0100;
    step();
    chk("pre_rst.sel", 32'({bus_i.s1, bus_i.s0}), 32'd2);
    #4;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 2'b00, 4'b0000, 1'b0, 1'b0);
    bus_i.req = 4'b0000;
    step();
    rst_n = 1'b1;

    // all four requesters held, granted bit dropped for one cycle after ack
    for (int t = 0; t < 5; t++) exp_g[t] = RR ? (t % 4) : 0;
    for (int t = 0; t < 5; t++) begin
      bus_i.req = 4'b1111;
      step();
      chk($sformatf("rr%0d.sel", t), 32'({bus_i.s1, bus_i.s0}), 32'(exp_g[t]));
      step();
      chk($sformatf("rr%0d.settle_ack", t), 32'(bus_i.ack), 32'd0);
      step();
      chk($sformatf("rr%0d.ack", t), 32'(bus_i.ack), 32'(oh(exp_g[t])));
      chk($sformatf("rr%0d.q", t), 32'(bus_i.q), 32'(src_vals[exp_g[t]]));
      bus_i.req = 4'b1111 & ~oh(exp_g[t]);
      step();
      chk($sformatf("rr%0d.rel_ack", t), 32'(bus_i.ack), 32'd0);
      chk($sformatf("rr%0d.rel_busy", t), 32'(bus_i.busy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
